ga23_rom_arbiter: RTL

Shares the single 64-bit tile-ROM SDRAM channel between the three GA23 tilemap layer fetchers (ports A/B/C). Arbitration is round-robin with level req / pulse rdy handshakes. Each 64-bit line returned is split into the 32-bit word the requester asked for. It sits between the per-layer fetch logic and the system SDRAM controller. An optional per-port single-line cache answers repeat accesses to the same 64-bit line without touching SDRAM.

---
 rtl/ga23_pkg.sv | 30 +++
 rtl/ga23_rom_line_cache.sv | 37 +++
 rtl/ga23_rom_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ga23_pkg.sv
// Shared types and constants for the GA23 tile-ROM arbiter and its line cache.
// Holds the arbiter state enum, port count, line/word widths and small helpers.
// Word select picks the 32-bit half of a 64-bit line addressed by addr[0].
package ga23_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } rom_arb_state_t;

   localparam int NUM_ROM_PORTS = 3;
   localparam int ROM_LINE_W    = 64;
   localparam int ROM_WORD_W    = 32;
   localparam int ROM_ADDR_W    = 21;
   localparam int ROM_TAG_W     = ROM_ADDR_W - 1;
   localparam int SDR_ADDR_W    = 25;

   // Round-robin successor: A(0) -> B(1) -> C(2) -> A(0).
   function automatic logic [1:0] port_after(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Select the requested 32-bit word from a 64-bit line.
   function automatic logic [ROM_WORD_W-1:0] word_of(input logic [ROM_LINE_W-1:0] line,
                                                     input logic                  sel);
      return sel ? line[ROM_LINE_W-1:ROM_WORD_W] : line[ROM_WORD_W-1:0];
   endfunction

endpackage

// File: rtl/ga23_rom_line_cache.sv
// Single-line tile-ROM cache for one requester port: tag, 64-bit line and valid bit.
// Lookup is combinational from registered state; a fill takes effect the next cycle.
// No backpressure: fills are accepted unconditionally, valid clears only on reset.
module ga23_rom_line_cache
   import ga23_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ROM_TAG_W-1:0]  lookup_tag_i,
   input  logic                  fill_i,
   input  logic [ROM_TAG_W-1:0]  fill_tag_i,
   input  logic [ROM_LINE_W-1:0] fill_line_i,
   output logic                  hit_o,
   output logic [ROM_LINE_W-1:0] line_o
);

   logic                  valid_q;
   logic [ROM_TAG_W-1:0]  tag_q;
   logic [ROM_LINE_W-1:0] line_q;

   // Capture every SDRAM fill for this port; the newest line always replaces the old one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         line_q  <= '0;
      end else if (fill_i) begin
         valid_q <= 1'b1;
         tag_q   <= fill_tag_i;
         line_q  <= fill_line_i;
      end
   end

   assign hit_o  = valid_q && (tag_q == lookup_tag_i);
   assign line_o = line_q;

endmodule

// File: rtl/ga23_rom_arbiter.sv
// Round-robin share of the 64-bit tile-ROM SDRAM channel between layer fetchers A/B/C.
// Latency: miss rdy one cycle after sdr_rdy; hit rdy one cycle after grant (GA23_ROM_LINE_CACHE_EN).
// Backpressure: level req held until one-cycle rdy; losers wait with req held; sdr_req held until sdr_rdy.
module ga23_rom_arbiter
   import ga23_pkg::*;
#(
   parameter logic [SDR_ADDR_W-1:0] ROM_BASE = 25'h0
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ROM_ADDR_W-1:0] addr_a_i,
   input  logic [ROM_ADDR_W-1:0] addr_b_i,
   input  logic [ROM_ADDR_W-1:0] addr_c_i,
   input  logic                  req_a_i,
   input  logic                  req_b_i,
   input  logic                  req_c_i,
   output logic [ROM_WORD_W-1:0] data_a_o,
   output logic [ROM_WORD_W-1:0] data_b_o,
   output logic [ROM_WORD_W-1:0] data_c_o,
   output logic                  rdy_a_o,
   output logic                  rdy_b_o,
   output logic                  rdy_c_o,
   output logic [SDR_ADDR_W-1:0] sdr_addr_o,
   output logic                  sdr_req_o,
   input  logic [ROM_LINE_W-1:0] sdr_data_i,
   input  logic                  sdr_rdy_i
);

   rom_arb_state_t              state_q;
   logic [1:0]                  ptr_q;
   logic [1:0]                  gnt_q;
   logic [ROM_TAG_W-1:0]        line_addr_q;
   logic                        word_sel_q;
   logic                        sdr_req_q;
   logic [SDR_ADDR_W-1:0]       sdr_addr_q;
   logic [NUM_ROM_PORTS-1:0]    rdy_q;
   logic [ROM_WORD_W-1:0]       data_q [NUM_ROM_PORTS];

   logic [ROM_ADDR_W-1:0]       addr_arr [NUM_ROM_PORTS];
   logic [NUM_ROM_PORTS-1:0]    req_vec;
   logic [NUM_ROM_PORTS-1:0]    hit_vec;
   logic [ROM_WORD_W-1:0]       hit_word;
   logic [1:0]                  cand0, cand1, cand2;
   logic                        pick_vld;
   logic [1:0]                  pick_idx;
   logic                        pick_hit;
   logic                        fill_en;

   assign addr_arr[0] = addr_a_i;
   assign addr_arr[1] = addr_b_i;
   assign addr_arr[2] = addr_c_i;
   assign req_vec     = {req_c_i, req_b_i, req_a_i};

   assign cand0 = ptr_q;
   assign cand1 = port_after(cand0);
   assign cand2 = port_after(cand1);

   // Pick the first requesting port at or after the round-robin pointer.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = cand0;
      if (req_vec[cand0]) begin
         pick_vld = 1'b1;
         pick_idx = cand0;
      end else if (req_vec[cand1]) begin
         pick_vld = 1'b1;
         pick_idx = cand1;
      end else if (req_vec[cand2]) begin
         pick_vld = 1'b1;
         pick_idx = cand2;
      end
   end

   assign fill_en  = (state_q == ISSUE) && sdr_rdy_i;
   assign pick_hit = hit_vec[pick_idx];

`ifdef GA23_ROM_LINE_CACHE_EN
   logic [ROM_LINE_W-1:0] cache_line [NUM_ROM_PORTS];

   for (genvar p = 0; p < NUM_ROM_PORTS; p++) begin : g_cache
      ga23_rom_line_cache u_cache (
         .clk          (clk),
         .reset        (reset),
         .lookup_tag_i (addr_arr[p][ROM_ADDR_W-1:1]),
         .fill_i       (fill_en && (gnt_q == 2'(p))),
         .fill_tag_i   (line_addr_q),
         .fill_line_i  (sdr_data_i),
         .hit_o        (hit_vec[p]),
         .line_o       (cache_line[p])
      );
   end

   assign hit_word = word_of(cache_line[pick_idx], addr_arr[pick_idx][0]);
`else
   assign hit_vec  = '0;
   assign hit_word = '0;
`endif

   // Arbitration FSM: grant in IDLE, wait for the SDRAM line in ISSUE, pulse rdy in RESP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= 2'd0;
         gnt_q       <= 2'd0;
         line_addr_q <= '0;
         word_sel_q  <= 1'b0;
         sdr_req_q   <= 1'b0;
         sdr_addr_q  <= '0;
         rdy_q       <= '0;
         for (int p = 0; p < NUM_ROM_PORTS; p++) data_q[p] <= '0;
      end else begin
         rdy_q <= '0;
         case (state_q)
            IDLE: begin
               if (pick_vld) begin
                  gnt_q       <= pick_idx;
                  ptr_q       <= port_after(pick_idx);
                  line_addr_q <= addr_arr[pick_idx][ROM_ADDR_W-1:1];
                  word_sel_q  <= addr_arr[pick_idx][0];
                  if (pick_hit) begin
                     data_q[pick_idx] <= hit_word;
                     rdy_q[pick_idx]  <= 1'b1;
                     state_q          <= RESP;
                  end else begin
                     sdr_req_q  <= 1'b1;
                     sdr_addr_q <= ROM_BASE + {2'b00, addr_arr[pick_idx][ROM_ADDR_W-1:1], 3'b000};
                     state_q    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (sdr_rdy_i) begin
                  sdr_req_q     <= 1'b0;
                  data_q[gnt_q] <= word_of(sdr_data_i, word_sel_q);
                  rdy_q[gnt_q]  <= 1'b1;
                  state_q       <= RESP;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign sdr_req_o  = sdr_req_q;
   assign sdr_addr_o = sdr_addr_q;
   assign rdy_a_o    = rdy_q[0];
   assign rdy_b_o    = rdy_q[1];
   assign rdy_c_o    = rdy_q[2];
   assign data_a_o   = data_q[0];
   assign data_b_o   = data_q[1];
   assign data_c_o   = data_q[2];

endmodule
